instruction_fetch: RTL and testbench

Sequential instruction-fetch requester for the tinycpu instruction decoder. It occupies device port 1 of the three-port memory controller and issues read requests at a 10-bit word-aligned PC. Each acknowledged word is tagged with its PC and pushed into a small show-ahead FIFO that the decoder drains with a valid/ready handshake. A redirect input restarts fetching at a new PC and discards stale data, including a response still in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 103 ++++++++++
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction-fetch block.
//   - fetch_state_t : fetch FSM state encoding (IDLE / REQ / DISCARD)
//   - ADDR_W_DEFAULT, DATA_W_DEFAULT : default PC and instruction widths
//   - PC_INC : byte increment between consecutive instruction words
package fetch_pkg;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT = 32;
    localparam int PC_INC         = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous show-ahead FIFO with a registered head entry.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   push       : write push_data this cycle (caller guarantees a free slot)
//   pop        : consume the head entry (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   push_data  : entry to write
//   head       : registered head entry, valid whenever level != 0
//   level      : number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEFAULT + DATA_W_DEFAULT,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        push_data,
    output logic [WIDTH-1:0]        head,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             pop_ok;

    assign pop_ok     = pop && (level_reg != '0);
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    // Storage array; no reset needed, entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        level_next  = level_reg;
        head_next   = head_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_next = rd_ptr_inc;
            end
            if (push && !pop_ok) begin
                level_next = level_reg + LVL_W'(1);
            end else if (!push && pop_ok) begin
                level_next = level_reg - LVL_W'(1);
            end
            // Head register tracks the oldest entry so it is visible without a pop.
            // When the FIFO drains to one entry and a push lands in the same
            // cycle, the pushed word bypasses the array into the head.
            if (pop_ok) begin
                if (level_reg > LVL_W'(1)) begin
                    head_next = mem[rd_ptr_inc];
                end else if (push) begin
                    head_next = push_data;
                end
            end else if (push && (level_reg == '0)) begin
                head_next = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= RESET_HEAD;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            level_reg  <= level_next;
            head_reg   <= head_next;
        end
    end

    assign head  = head_reg;
    assign level = level_reg;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential instruction-fetch requester (memory port 1).
// Issues word reads at the PC, tags each acknowledged word with its PC and
// buffers it in a show-ahead FIFO drained by the decoder (valid/ready).
// A redirect restarts fetching at a new PC and discards stale data,
// including a response still in flight.
// Build option: define FETCH_BURST_EN to keep requesting back-to-back words
// while the FIFO has room (mem_burst_en then mirrors mem_en).
// Ports:
//   clk, reset (async, active-low)
//   redirect_valid, redirect_pc     : flush and refetch from redirect_pc
//   mem_en, mem_burst_en, mem_we, mem_addr, mem_di : request to controller
//   mem_ack, mem_do                 : acknowledge and read data
//   instr_valid, instr_data, instr_pc, instr_ready : decoder handshake
//   fifo_level                      : current FIFO occupancy
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         mem_en,
    output logic                         mem_burst_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_di,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_do,
    output logic                         instr_valid,
    output logic [DATA_W-1:0]            instr_data,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] redirect_pc_aligned;
    logic fifo_push, fifo_pop, fifo_flush, fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    assign redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);
    assign fifo_pop  = instr_valid && instr_ready;
    assign fifo_full = (fifo_level == LVL_W'(FIFO_DEPTH));

`ifdef FETCH_BURST_EN
    localparam int LA_W = LVL_W + 1;
    logic [LA_W-1:0] level_after_push;
    logic            room_after_push;

    // Occupancy once this cycle's push and any concurrent pop have landed.
    assign level_after_push = {1'b0, fifo_level} + LA_W'(1) - LA_W'(fifo_pop);
    assign room_after_push  = (level_after_push < LA_W'(FIFO_DEPTH));
    assign mem_burst_en     = mem_en;
`else
    assign mem_burst_en = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_next    = redirect_pc_aligned;
                end else if (!fifo_full) begin
                    // Entering REQ reserves a free slot for the eventual push.
                    state_next = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_next    = redirect_pc_aligned;
                    // A simultaneous ack retires the request; otherwise its
                    // ack is still owed and must be swallowed in DISCARD.
                    state_next = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    fifo_push  = 1'b1;
                    pc_next    = pc_reg + ADDR_W'(PC_INC);
                    state_next = IDLE;
`ifdef FETCH_BURST_EN
                    if (room_after_push) begin
                        state_next = REQ;
                    end
`endif
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc_aligned;
                end
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo #(
        .WIDTH      (ADDR_W + DATA_W),
        .DEPTH      (FIFO_DEPTH),
        .RESET_HEAD ({RESET_PC, {DATA_W{1'b0}}})
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_data ({pc_reg, mem_do}),
        .head      (fifo_head),
        .level     (fifo_level)
    );

    assign mem_en      = (state_reg == REQ);
    assign mem_we      = 1'b0;
    assign mem_addr    = pc_reg;
    assign mem_di      = '0;
    assign instr_valid = (fifo_level != '0);
    assign instr_pc    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign instr_data  = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic for
// instruction_fetch, checked every cycle against a transaction-level model
// (request outstanding / cancelled flags, a PC and a queue of fetched words).
module tb_instruction_fetch;

    localparam int DEPTH = 4;
    localparam logic [9:0] RESET_PC = 10'd0;
`ifdef FETCH_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        mem_en, mem_burst_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_di;
    logic        mem_ack;
    logic [31:0] mem_do;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [9:0]  instr_pc;
    logic        instr_ready;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    entry_t     m_q[$];
    logic [9:0] m_pc;
    bit         m_busy;    // a request has been issued and not yet acked
    bit         m_cancel;  // that request was cancelled by a redirect

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_en         (mem_en),
        .mem_burst_en   (mem_burst_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_di         (mem_di),
        .mem_ack        (mem_ack),
        .mem_do         (mem_do),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one clock edge to the model with the given inputs.
    task automatic model_edge(input logic rv, input logic [9:0] rpc, input logic ack,
                              input logic [31:0] d, input logic rdy);
        int         lvl;
        bit         do_pop;
        logic [9:0] tpc;
        entry_t     e;
        lvl    = m_q.size();
        do_pop = (lvl != 0) && rdy;
        tpc    = {rpc[9:2], 2'b00};
        if (do_pop && !rv) begin
            $display("txn pop pc=%03h data=%08h", m_q[0].pc, m_q[0].data);
        end
        if (m_busy && !m_cancel) begin
            if (rv) begin
                m_q.delete();
                m_pc = tpc;
                if (ack) m_busy = 0;
                else     m_cancel = 1;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (ack) begin
                    e.pc = m_pc;
                    e.data = d;
                    m_q.push_back(e);
                    m_pc = m_pc + 10'd4;
                    m_busy = BURST && (m_q.size() < DEPTH);
                end
            end
        end else if (m_busy) begin
            if (do_pop) void'(m_q.pop_front());
            if (rv) m_pc = tpc;
            if (ack) begin
                m_busy = 0;
                m_cancel = 0;
            end
        end else begin
            if (rv) begin
                m_q.delete();
                m_pc = tpc;
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (lvl < DEPTH) m_busy = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_en;
        exp_en = m_busy && !m_cancel;
        check_eq("mem_en", mem_en, exp_en);
        check_eq("mem_burst_en", mem_burst_en, BURST ? exp_en : 1'b0);
        check_eq("mem_addr", mem_addr, m_pc);
        check_eq("mem_we", mem_we, 1'b0);
        check_eq("fifo_level", fifo_level, m_q.size());
        check_eq("instr_valid", instr_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check_eq("instr_pc", instr_pc, m_q[0].pc);
            check_eq("instr_data", instr_data, m_q[0].data);
        end
    endtask

    task automatic step(input logic rv, input logic [9:0] rpc, input logic ack,
                        input logic [31:0] d, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        mem_ack        = ack;
        mem_do         = d;
        instr_ready    = rdy;
        model_edge(rv, rpc, ack, d, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        redirect_valid = 0;
        redirect_pc    = 0;
        mem_ack        = 0;
        mem_do         = 0;
        instr_ready    = 0;
        reset          = 0;
        #2;
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_burst_en", mem_burst_en, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_addr", mem_addr, RESET_PC);
        check_eq("rst_mem_di", mem_di, 32'd0);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_fifo_level", fifo_level, 3'd0);
        check_eq("rst_instr_pc", instr_pc, RESET_PC);
        m_q.delete();
        m_pc     = RESET_PC;
        m_busy   = 0;
        m_cancel = 0;
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    // Advance until a live request is shown; acks any cancelled request owed.
    task automatic wait_req(input logic rdy);
        int n = 0;
        while (!(m_busy && !m_cancel) && n < 20) begin
            step(1'b0, 10'd0, m_busy, 32'd0, rdy);
            n++;
        end
        if (!(m_busy && !m_cancel)) check_eq("wait_req", mem_en, 1'b1);
    endtask

    task automatic ack_word(input logic [31:0] d, input logic rdy);
        wait_req(rdy);
        step(1'b0, 10'd0, 1'b1, d, rdy);
    endtask

    initial begin
        int thr;
        reset = 1;
        redirect_valid = 0; redirect_pc = 0; mem_ack = 0; mem_do = 0; instr_ready = 0;
        #1;
        do_reset();

        // Reset and first fetch
        step(1'b0, 10'd0, 1'b0, 32'd0, 1'b1);
        check_eq("t1_first_en", mem_en, 1'b1);
        ack_word(32'hA0, 1'b1);
        check_eq("t1_pc0", instr_pc, 10'h000);
        check_eq("t1_data0", instr_data, 32'hA0);
        ack_word(32'hA1, 1'b1);
        check_eq("t1_pc1", instr_pc, 10'h004);
        check_eq("t1_data1", instr_data, 32'hA1);

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) ack_word(32'h100 + i, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 10'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t2_level_full", fifo_level, 3'd4);
        check_eq("t2_en_low", mem_en, 1'b0);
        step(1'b0, 10'd0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 32'd0, 1'b0);
        check_eq("t2_rearm_en", mem_en, 1'b1);
        check_eq("t2_rearm_addr", mem_addr, 10'h010);

        // Redirect while waiting, then the cancelled ack arrives
        step(1'b1, 10'h104, 1'b0, 32'd0, 1'b0);
        check_eq("t3_valid_after_redir", instr_valid, 1'b0);
        step(1'b0, 10'd0, 1'b1, 32'hDEAD, 1'b0);
        check_eq("t3_dead_hidden", instr_valid, 1'b0);
        wait_req(1'b0);
        check_eq("t3_next_addr", mem_addr, 10'h104);

        // Redirect with simultaneous ack
        step(1'b1, 10'h200, 1'b1, 32'hBEEF, 1'b0);
        check_eq("t4_level", fifo_level, 3'd0);
        wait_req(1'b0);
        check_eq("t4_next_addr", mem_addr, 10'h200);

        // Wrap-around (unaligned redirect target, low bits dropped)
        do_reset();
        step(1'b1, 10'h3FE, 1'b0, 32'd0, 1'b0);
        ack_word(32'h11, 1'b0);
        ack_word(32'h22, 1'b0);
        check_eq("t5_pc_3fc", instr_pc, 10'h3FC);
        step(1'b0, 10'd0, 1'b0, 32'd0, 1'b1);
        check_eq("t5_pc_wrap", instr_pc, 10'h000);
        check_eq("t5_data_wrap", instr_data, 32'h22);

`ifdef FETCH_BURST_EN
        // Burst: back-to-back acks with an empty FIFO
        do_reset();
        wait_req(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'd0, 1'b1, 32'hC0 + i, 1'b0);
            check_eq("t6_en_high", mem_en, 1'b1);
            check_eq("t6_level", fifo_level, 3'(i + 1));
            check_eq("t6_burst_en", mem_burst_en, 1'b1);
        end
`endif

        // Randomized traffic with varying decoder backpressure
        do_reset();
        thr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) thr = $urandom_range(15, 90);
            if (c % 700 == 699) do_reset();
            step(($urandom_range(0, 99) < 6),
                 10'($urandom_range(0, 1023)),
                 m_busy && ($urandom_range(0, 99) < 55),
                 $urandom,
                 ($urandom_range(0, 99) < thr));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
